// File: rtl/spi_coeff_master.sv
// SPI mode-0 master that streams NTaps-word coefficient frames, MSB first,
// from a 1-deep valid/ready word buffer onto cs/mosi/spiClk.
module spi_coeff_master #(
    parameter int NTaps      = 9,
    parameter int CoeffWidth = 16,
    parameter int ClkDiv     = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [CoeffWidth-1:0] coeffData,
    input  logic                  coeffValid,
    output logic                  coeffReady,
    output logic                  busy,
    output logic                  frameDone,
    output logic                  cs,
    output logic                  mosi,
    output logic                  spiClk
);
    localparam int BW = (CoeffWidth > 1) ? $clog2(CoeffWidth) : 1;
    localparam int WW = (NTaps > 1) ? $clog2(NTaps) : 1;
    localparam int DW = (ClkDiv > 1) ? $clog2(ClkDiv) : 1;

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, STALL, HOLD, GAP} state_t;

    state_t                state, state_nxt;
    logic [CoeffWidth-1:0] word_buf, sh_reg;
    logic                  buf_full;
    logic [BW-1:0]         bit_cnt;
    logic [WW-1:0]         word_cnt;
    logic [DW-1:0]         div_cnt;
    logic                  div_run, tick, end_bit, last_word;
    logic                  load, new_frame, shift, toggle, done;

    assign div_run    = (state == SETUP) || (state == SHIFT) || (state == HOLD) || (state == GAP);
    assign tick       = div_run && (div_cnt == DW'(ClkDiv - 1));
    assign end_bit    = (bit_cnt == BW'(CoeffWidth - 1));
    assign last_word  = (word_cnt == WW'(NTaps - 1));
    assign cs         = (state == IDLE) || (state == GAP);
    assign busy       = (state != IDLE);
    assign coeffReady = !buf_full;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        new_frame = 1'b0;
        shift     = 1'b0;
        toggle    = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: if (buf_full) begin
                load      = 1'b1;
                new_frame = 1'b1;
                state_nxt = SETUP;
            end
            SETUP: if (tick) state_nxt = SHIFT;
            SHIFT: if (tick) begin
                toggle = 1'b1;
                // Only the falling half of a bit advances data or ends a word.
                if (spiClk) begin
                    if (!end_bit)       shift     = 1'b1;
                    else if (last_word) state_nxt = HOLD;
                    else if (buf_full)  load      = 1'b1;
                    else                state_nxt = STALL;
                end
            end
            STALL: if (buf_full) begin
                load      = 1'b1;
                state_nxt = SETUP;
            end
            HOLD: if (tick) state_nxt = GAP;
            GAP: if (tick) begin
                done = 1'b1;
                // A waiting word starts the next frame straight away, so the
                // cs-high gap is exactly one divider period.
                if (buf_full) begin
                    load      = 1'b1;
                    new_frame = 1'b1;
                    state_nxt = SETUP;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            word_buf  <= '0;
            buf_full  <= 1'b0;
            sh_reg    <= '0;
            bit_cnt   <= '0;
            word_cnt  <= '0;
            div_cnt   <= '0;
            spiClk    <= 1'b0;
            mosi      <= 1'b0;
            frameDone <= 1'b0;
        end else begin
            frameDone <= done;
            div_cnt   <= (div_run && !tick) ? div_cnt + DW'(1) : '0;
            if (toggle) spiClk <= ~spiClk;
            // Accept and load are exclusive: accept needs an empty buffer, load a full one.
            if (coeffValid && !buf_full) begin
                word_buf <= coeffData;
                buf_full <= 1'b1;
            end else if (load) begin
                buf_full <= 1'b0;
            end
            if (load) begin
                sh_reg   <= word_buf;
                mosi     <= word_buf[CoeffWidth-1];
                bit_cnt  <= '0;
                word_cnt <= new_frame ? '0 : word_cnt + WW'(1);
            end else if (shift) begin
                sh_reg  <= {sh_reg[CoeffWidth-2:0], 1'b0};
                mosi    <= sh_reg[CoeffWidth-2];
                bit_cnt <= bit_cnt + BW'(1);
            end
        end
    end
endmodule

// File: tb/tb_spi_coeff_master.sv
// Directed bench: a ClkDiv=2 and a ClkDiv=1 instance share one feeder and one
// mode-0 slave monitor, selected by sel.
module tb_spi_coeff_master;
    logic        clk = 1'b0;
    logic        reset;
    logic        sel;
    logic [15:0] coeffData;
    logic        coeffValid;
    logic        coeffValid0, coeffReady0, busy0, frameDone0, cs0, mosi0, spiClk0;
    logic        coeffValid1, coeffReady1, busy1, frameDone1, cs1, mosi1, spiClk1;
    logic        coeffReady, busy, frameDone, cs, mosi, spiClk;

    initial forever #5 clk = ~clk;

    assign coeffValid0 = coeffValid & ~sel;
    assign coeffValid1 = coeffValid & sel;
    assign coeffReady  = sel ? coeffReady1 : coeffReady0;
    assign busy        = sel ? busy1      : busy0;
    assign frameDone   = sel ? frameDone1 : frameDone0;
    assign cs          = sel ? cs1        : cs0;
    assign mosi        = sel ? mosi1      : mosi0;
    assign spiClk      = sel ? spiClk1    : spiClk0;

    spi_coeff_master #(.NTaps(9), .CoeffWidth(16), .ClkDiv(2)) dut0 (
        .clk(clk), .reset(reset), .coeffData(coeffData), .coeffValid(coeffValid0),
        .coeffReady(coeffReady0), .busy(busy0), .frameDone(frameDone0),
        .cs(cs0), .mosi(mosi0), .spiClk(spiClk0));

    spi_coeff_master #(.NTaps(9), .CoeffWidth(16), .ClkDiv(1)) dut1 (
        .clk(clk), .reset(reset), .coeffData(coeffData), .coeffValid(coeffValid1),
        .coeffReady(coeffReady1), .busy(busy1), .frameDone(frameDone1),
        .cs(cs1), .mosi(mosi1), .spiClk(spiClk1));

    int checks = 0;
    int errors = 0;

    // feeder
    logic [15:0] feed_words [0:31];
    int          feed_idx = 0, feed_n = 0, stall_idx = -1, stall_left = 0;
    logic        rdy_seen = 1'b0;

    initial begin
        coeffValid = 1'b0;
        coeffData  = '0;
        forever begin
            @(negedge clk);
            if (coeffValid && rdy_seen) feed_idx++;
            if (feed_idx == stall_idx && stall_left > 0) begin
                coeffValid = 1'b0;
                stall_left--;
            end else if (feed_idx < feed_n) begin
                coeffValid = 1'b1;
                coeffData  = feed_words[feed_idx];
            end else begin
                coeffValid = 1'b0;
            end
            rdy_seen = coeffReady;
        end
    end

    // mode-0 slave and timing monitor
    logic [15:0] cap_words [$];
    logic [15:0] cap_sh = '0;
    int   cap_bits = 0, cs_low_cnt = 0, cs_high_cnt = 0, last_cs_low = 0, last_gap = 0;
    int   done_cnt = 0, done_gap = -1, low_run = 0, max_low_run = 0, mosi_bad = 0;
    int   cyc = 0, last_rise = 0, last_period = 0;
    logic prev_clk = 1'b0, prev_mosi = 1'b0, prev_busy = 1'b0, done_busy = 1'b1, done_prev_busy = 1'b0;

    initial forever begin
        @(negedge clk);
        cyc++;
        if (reset) begin
            cap_bits = 0; cs_low_cnt = 0; cs_high_cnt = 0; low_run = 0;
        end else begin
            if (!cs) begin
                if (cs_high_cnt > 0) last_gap = cs_high_cnt;
                cs_high_cnt = 0;
                cs_low_cnt++;
                if (spiClk && !prev_clk) begin
                    cap_sh = {cap_sh[14:0], mosi};
                    cap_bits++;
                    if (cap_bits == 16) begin
                        cap_words.push_back(cap_sh);
                        cap_bits = 0;
                    end
                    last_period = cyc - last_rise;
                    last_rise   = cyc;
                end
                if (!spiClk) low_run++;
                else begin
                    if (low_run > max_low_run) max_low_run = low_run;
                    low_run = 0;
                end
            end else begin
                if (cs_low_cnt > 0) last_cs_low = cs_low_cnt;
                cs_low_cnt = 0;
                cs_high_cnt++;
                cap_bits = 0;
                low_run  = 0;
            end
            if (spiClk && mosi !== prev_mosi) mosi_bad++;
            if (frameDone) begin
                done_cnt++;
                done_gap       = cs ? cs_high_cnt - 1 : -1;
                done_busy      = busy;
                done_prev_busy = prev_busy;
            end
        end
        prev_clk  = spiClk;
        prev_mosi = mosi;
        prev_busy = busy;
    end

    task automatic clear_mon();
        cap_words.delete();
        done_cnt = 0; done_gap = -1; max_low_run = 0; last_gap = 0;
        mosi_bad = 0; last_cs_low = 0; last_period = 0;
    endtask

    task automatic start_feed(input int n);
        feed_idx = 0;
        feed_n   = n;
    endtask

    task automatic wait_done(input int target, input int budget, input string tag);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        checks++;
        if (done_cnt < target) begin
            errors++;
            $display("FAIL %s timeout: frameDone count %0d, required %0d", tag, done_cnt, target);
        end
        repeat (4) @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        sel   = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({cs, spiClk, mosi, busy, frameDone, coeffReady} !== 6'b100001) begin
            errors++;
            $display("FAIL reset_state got %b required 100001", {cs, spiClk, mosi, busy, frameDone, coeffReady});
        end
        reset = 1'b0;
        @(negedge clk); #1;
    endtask

    task automatic test_frame();
        for (int i = 0; i < 9; i++) feed_words[i] = 16'(i + 1);
        clear_mon();
        start_feed(9);
        wait_done(1, 2000, "frame");
        checks++;
        if (cap_words.size() != 9) begin
            errors++; $display("FAIL frame_count got %0d required 9", cap_words.size());
        end
        for (int i = 0; i < 9 && i < cap_words.size(); i++) begin
            checks++;
            if (cap_words[i] !== 16'(i + 1)) begin
                errors++; $display("FAIL frame_word%0d got %h required %h", i, cap_words[i], 16'(i + 1));
            end
        end
        checks++;
        if (last_cs_low != 580) begin errors++; $display("FAIL frame_cs_low got %0d required 580", last_cs_low); end
        checks++;
        if (done_gap != 2) begin errors++; $display("FAIL frame_done_delay got %0d required 2", done_gap); end
        checks++;
        if (done_cnt != 1) begin errors++; $display("FAIL frame_done_pulses got %0d required 1", done_cnt); end
        checks++;
        if ({done_prev_busy, done_busy} !== 2'b10) begin
            errors++; $display("FAIL frame_busy_fall got %b required 10", {done_prev_busy, done_busy});
        end
        checks++;
        if (mosi_bad != 0) begin errors++; $display("FAIL frame_mosi_stable got %0d required 0", mosi_bad); end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 9; i++) feed_words[i] = 16'(i + 1);
        clear_mon();
        stall_idx  = 3;
        stall_left = 200;
        start_feed(9);
        wait_done(1, 3000, "stall");
        stall_idx = -1;
        checks++;
        if (max_low_run <= 4) begin errors++; $display("FAIL stall_seen low_run %0d required >4", max_low_run); end
        checks++;
        if (last_cs_low != 580 + (max_low_run - 4) + 2) begin
            errors++; $display("FAIL stall_cs_low got %0d required %0d", last_cs_low, 580 + (max_low_run - 4) + 2);
        end
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (i >= cap_words.size() || cap_words[i] !== 16'(i + 1)) begin
                errors++; $display("FAIL stall_word%0d got %h required %h", i,
                                   (i < cap_words.size()) ? cap_words[i] : 16'hxxxx, 16'(i + 1));
            end
        end
    endtask

    task automatic test_pattern();
        for (int i = 0; i < 9; i++) feed_words[i] = (i % 2 == 0) ? 16'h8001 : 16'h7FFE;
        clear_mon();
        start_feed(9);
        wait_done(1, 2000, "pattern");
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (i >= cap_words.size() || cap_words[i] !== ((i % 2 == 0) ? 16'h8001 : 16'h7FFE)) begin
                errors++; $display("FAIL pattern_word%0d got %h required %h", i,
                                   (i < cap_words.size()) ? cap_words[i] : 16'hxxxx,
                                   (i % 2 == 0) ? 16'h8001 : 16'h7FFE);
            end
        end
        checks++;
        if (mosi_bad != 0) begin errors++; $display("FAIL pattern_mosi_stable got %0d required 0", mosi_bad); end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        for (int i = 0; i < 9; i++) feed_words[i] = 16'(i + 1);
        clear_mon();
        start_feed(9);
        while (!(cap_words.size() == 2 && cap_bits >= 4) && n < 2000) begin
            @(negedge clk); #1;
            n++;
        end
        checks++;
        if (cap_words.size() != 2) begin
            errors++; $display("FAIL rstmid_reach words %0d required 2", cap_words.size());
        end
        reset      = 1'b1;
        coeffValid = 1'b0;
        feed_n     = feed_idx;
        @(negedge clk); #1;
        checks++;
        if ({cs, spiClk, mosi, busy, coeffReady} !== 5'b10001) begin
            errors++; $display("FAIL rstmid_state got %b required 10001", {cs, spiClk, mosi, busy, coeffReady});
        end
        reset = 1'b0;
        @(negedge clk); #1;
        for (int i = 0; i < 9; i++) feed_words[i] = 16'hA5A5;
        clear_mon();
        start_feed(9);
        wait_done(1, 2000, "rstmid");
        checks++;
        if (cap_words.size() != 9) begin
            errors++; $display("FAIL rstmid_count got %0d required 9", cap_words.size());
        end
        for (int i = 0; i < 9 && i < cap_words.size(); i++) begin
            checks++;
            if (cap_words[i] !== 16'hA5A5) begin
                errors++; $display("FAIL rstmid_word%0d got %h required a5a5", i, cap_words[i]);
            end
        end
        checks++;
        if (last_cs_low != 580) begin errors++; $display("FAIL rstmid_cs_low got %0d required 580", last_cs_low); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 18; i++) feed_words[i] = 16'(i + 1);
        clear_mon();
        start_feed(18);
        wait_done(2, 4000, "b2b");
        checks++;
        if (cap_words.size() != 18) begin
            errors++; $display("FAIL b2b_count got %0d required 18", cap_words.size());
        end
        checks++;
        if (cap_words.size() < 10 || cap_words[9] !== 16'h000A) begin
            errors++; $display("FAIL b2b_frame2_first got %h required 000a",
                               (cap_words.size() >= 10) ? cap_words[9] : 16'hxxxx);
        end
        checks++;
        if (last_gap != 2) begin errors++; $display("FAIL b2b_gap got %0d required 2", last_gap); end
        checks++;
        if (done_cnt != 2) begin errors++; $display("FAIL b2b_done_pulses got %0d required 2", done_cnt); end
    endtask

    task automatic test_clkdiv1();
        sel = 1'b1;
        @(negedge clk); #1;
        for (int i = 0; i < 9; i++) feed_words[i] = 16'h1234 + 16'(i);
        clear_mon();
        start_feed(9);
        wait_done(1, 2000, "div1");
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (i >= cap_words.size() || cap_words[i] !== 16'h1234 + 16'(i)) begin
                errors++; $display("FAIL div1_word%0d got %h required %h", i,
                                   (i < cap_words.size()) ? cap_words[i] : 16'hxxxx, 16'h1234 + 16'(i));
            end
        end
        checks++;
        if (last_period != 2) begin errors++; $display("FAIL div1_period got %0d required 2", last_period); end
        checks++;
        if (last_cs_low != 290) begin errors++; $display("FAIL div1_cs_low got %0d required 290", last_cs_low); end
    endtask

    initial begin
        reset = 1'b1;
        sel   = 1'b0;
        test_reset();
        test_frame();
        test_stall();
        test_pattern();
        test_reset_mid();
        test_back_to_back();
        test_clkdiv1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
